// File: rtl/wb_regbank_slave.sv
// Wishbone classic slave fronting an N-register bank.
// Handles byte-lane writes, latency-delayed reads and error termination.
module wb_regbank_slave #(
    parameter int              AW      = 16,
    parameter int              DW      = 16,
    parameter int              N_REGS  = 4,
    parameter logic [AW-1:0]   BASE    = '0,
    parameter int              STRIDE  = 2,
    parameter int              RD_LAT  = 1,
    parameter logic [N_REGS-1:0] RO_MASK = '0,
    localparam int             IDXW    = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int             SW      = DW / 8
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_adr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [SW-1:0]   i_wb_sel,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic [IDXW-1:0] o_reg_idx,
    output logic [DW-1:0]   o_reg_wdata,
    output logic [SW-1:0]   o_reg_be,
    output logic            o_reg_we,
    output logic            o_reg_re,
    input  logic [DW-1:0]   i_reg_rdata
);

    localparam int           SH    = $clog2(STRIDE);
    localparam int           NEXT  = 2 ** IDXW;
    localparam logic [AW:0]  SPAN  = (AW + 1)'(N_REGS * STRIDE);
    localparam logic [AW:0]  AMASK = (AW + 1)'(STRIDE - 1);
    localparam logic [NEXT-1:0] RO_EXT = NEXT'(RO_MASK);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ack_d, err_d, we_d, re_d;
    logic [DW-1:0]   data_d, wdata_d;
    logic [IDXW-1:0] idx_d;
    logic [SW-1:0]   be_d;

    // One extra bit keeps the subtraction and range compare from wrapping
    logic [AW:0]     off;
    logic            valid;
    logic [IDXW-1:0] idx;
    logic            ro;

    assign off   = {1'b0, i_wb_adr} - {1'b0, BASE};
    assign valid = (i_wb_adr >= BASE) && (off < SPAN) && ((off & AMASK) == '0);
    assign idx   = IDXW'(off >> SH);
    assign ro    = RO_EXT[idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        data_d  = o_wb_data;
        idx_d   = o_reg_idx;
        wdata_d = o_reg_wdata;
        be_d    = o_reg_be;
        unique case (state_q)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    if (!valid || (i_wb_we && ro)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (i_wb_we) begin
                        idx_d   = idx;
                        wdata_d = i_wb_data;
                        be_d    = i_wb_sel;
                        we_d    = |i_wb_sel;
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        idx_d   = idx;
                        re_d    = 1'b1;
                        cnt_d   = 4'(RD_LAT - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Master gave up the cycle: drop the read silently
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = i_reg_rdata;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_data   <= '0;
            o_reg_idx   <= '0;
            o_reg_wdata <= '0;
            o_reg_be    <= '0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_wb_ack    <= ack_d;
            o_wb_err    <= err_d;
            o_wb_data   <= data_d;
            o_reg_idx   <= idx_d;
            o_reg_wdata <= wdata_d;
            o_reg_be    <= be_d;
            o_reg_we    <= we_d;
            o_reg_re    <= re_d;
        end
    end

endmodule
